// File: rtl/mesm6_mem_pkg.sv
// Shared types and sizes for the mesm6 memory arbiter.
package mesm6_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 48;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DBUS_WAIT = 2'd1,
    IBUS_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mesm6_mem_arbiter_if.sv
// Core-side instruction/data buses plus the single external memory port.
interface mesm6_mem_arbiter_if;
  import mesm6_mem_pkg::*;

  logic              ibus_fetch;
  logic [ADDR_W-1:0] ibus_addr;
  logic [DATA_W-1:0] ibus_input;
  logic              ibus_done;
  logic              dbus_read;
  logic              dbus_write;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_output;
  logic [DATA_W-1:0] dbus_input;
  logic              dbus_done;
  logic              alu_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  ibus_fetch, ibus_addr, dbus_read, dbus_write, dbus_addr, dbus_output,
    input  alu_busy, mem_rdata, mem_ack,
    output ibus_input, ibus_done, dbus_input, dbus_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ibus_fetch, ibus_addr, dbus_read, dbus_write, dbus_addr, dbus_output,
    output alu_busy, mem_rdata, mem_ack,
    input  ibus_input, ibus_done, dbus_input, dbus_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mesm6_mem_chan.sv
// One arbiter channel: sticky done flag, held read-data word and pending flag.
module mesm6_mem_chan
  import mesm6_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              ack,
  input  logic              load,
  input  logic              hit,
  input  logic [DATA_W-1:0] rdata,
  input  logic              retire,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              pend
);

  logic              done_r;
  logic [DATA_W-1:0] data_r;

  // Done flag: a completion wins over retire so it can never be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
    end else if (ack | hit) begin
      done_r <= 1'b1;
    end else if (retire) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_r;
    end
  end

  // Read data only moves on this channel's own read completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= {DATA_W{1'b0}};
    end else if (ack & load) begin
      data_r <= rdata;
    end else begin
      data_r <= data_r;
    end
  end

  assign done = done_r;
  assign data = data_r;
  assign pend = req & ~done_r;

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// Merges the mesm6 instruction and data buses onto one memory port, dbus first.
// Optional macro MESM6_MEM_IBUS_HIT_EN serves a repeated fetch from the held word.
module mesm6_mem_arbiter
  import mesm6_mem_pkg::*;
(
  input logic               clk,
  input logic               reset,
  mesm6_mem_arbiter_if.slave bus
);

  arb_state_e        state_r;
  arb_state_e        state_nx_s;
  logic              mem_req_r;
  logic              mem_req_nx_s;
  logic              mem_we_r;
  logic              mem_we_nx_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_addr_nx_s;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] mem_wdata_nx_s;

  logic              ipend_s;
  logic              dpend_s;
  logic              ibus_done_s;
  logic              dbus_done_s;
  logic [DATA_W-1:0] ibus_data_s;
  logic [DATA_W-1:0] dbus_data_s;
  logic              iack_s;
  logic              dack_s;
  logic              ihit_s;
  logic              hit_ok_s;
  logic              dreq_s;
  logic              retire_s;

  assign dreq_s   = bus.dbus_read | bus.dbus_write;
  assign retire_s = (~bus.ibus_fetch | ibus_done_s) & (~dreq_s | dbus_done_s)
                  & (bus.ibus_fetch | dreq_s) & ~bus.alu_busy;

  mesm6_mem_chan u_ibus (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.ibus_fetch),
    .ack    (iack_s),
    .load   (1'b1),
    .hit    (ihit_s),
    .rdata  (bus.mem_rdata),
    .retire (retire_s),
    .done   (ibus_done_s),
    .data   (ibus_data_s),
    .pend   (ipend_s)
  );

  mesm6_mem_chan u_dbus (
    .clk    (clk),
    .reset  (reset),
    .req    (dreq_s),
    .ack    (dack_s),
    .load   (~mem_we_r),
    .hit    (1'b0),
    .rdata  (bus.mem_rdata),
    .retire (retire_s),
    .done   (dbus_done_s),
    .data   (dbus_data_s),
    .pend   (dpend_s)
  );

`ifdef MESM6_MEM_IBUS_HIT_EN
  logic [ADDR_W-1:0] last_iaddr_r;
  logic              last_ivalid_r;

  // Track the last fetched address; a data write to it invalidates the copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_iaddr_r  <= {ADDR_W{1'b0}};
      last_ivalid_r <= 1'b0;
    end else if (iack_s) begin
      last_iaddr_r  <= mem_addr_r;
      last_ivalid_r <= 1'b1;
    end else if (dack_s & mem_we_r & (mem_addr_r == last_iaddr_r)) begin
      last_iaddr_r  <= last_iaddr_r;
      last_ivalid_r <= 1'b0;
    end else begin
      last_iaddr_r  <= last_iaddr_r;
      last_ivalid_r <= last_ivalid_r;
    end
  end

  assign hit_ok_s = last_ivalid_r & (bus.ibus_addr == last_iaddr_r);
`else
  assign hit_ok_s = 1'b0;
`endif

  // State and memory-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      mem_req_r   <= mem_req_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
    end
  end

  // Next-state, launch and completion decode.
  always_comb begin
    state_nx_s     = state_r;
    mem_req_nx_s   = mem_req_r;
    mem_we_nx_s    = mem_we_r;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    iack_s         = 1'b0;
    dack_s         = 1'b0;
    ihit_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (dpend_s) begin
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = bus.dbus_write;
          mem_addr_nx_s  = bus.dbus_addr;
          mem_wdata_nx_s = bus.dbus_output;
          state_nx_s     = DBUS_WAIT;
        end else if (ipend_s) begin
          if (hit_ok_s) begin
            ihit_s = 1'b1;
          end else begin
            mem_req_nx_s  = 1'b1;
            mem_we_nx_s   = 1'b0;
            mem_addr_nx_s = bus.ibus_addr;
            state_nx_s    = IBUS_WAIT;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      DBUS_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_nx_s = 1'b0;
          dack_s       = 1'b1;
          state_nx_s   = IDLE;
        end else begin
          state_nx_s = DBUS_WAIT;
        end
      end
      IBUS_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_nx_s = 1'b0;
          iack_s       = 1'b1;
          state_nx_s   = IDLE;
        end else begin
          state_nx_s = IBUS_WAIT;
        end
      end
      default: begin
        mem_req_nx_s = 1'b0;
        state_nx_s   = IDLE;
      end
    endcase
  end

  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.ibus_done  = ibus_done_s;
  assign bus.ibus_input = ibus_data_s;
  assign bus.dbus_done  = dbus_done_s;
  assign bus.dbus_input = dbus_data_s;

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Self-checking bench for mesm6_mem_arbiter: vector table, corner sequences, random transactions.
module tb_mesm6_mem_arbiter;

`ifdef MESM6_MEM_IBUS_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [47:0] wdata;
  } acc_t;

  typedef struct {
    logic        f, r, w;
    logic [14:0] ia, da;
    logic [47:0] dout;
    int          busy;
    int          n;
    logic [14:0] a0, a1;
    logic        we0;
    logic [47:0] ei, ed;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mesm6_mem_arbiter_if bus();

  mesm6_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] tb_mem [logic [14:0]];
  logic [47:0] mmem   [logic [14:0]];
  acc_t        acc_q[$];
  acc_t        exp_q[$];
  acc_t        snap;
  bit          auto_mem;
  bit          req_seen;
  int          lat_cnt;
  int          lat_max;
  vec_t        vecs[8];

  function automatic logic [47:0] init_word(logic [14:0] a);
    return {a, 3'b101, ~a, a};
  endfunction

  function automatic logic [47:0] rd_world(logic [14:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [47:0] rd_model(logic [14:0] a);
    if (mmem.exists(a)) return mmem[a];
    return init_word(a);
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  function automatic logic [14:0] pick_addr();
    logic [31:0] t;
    case ($urandom_range(4, 0))
      0: return 15'o00100;
      1: return 15'o00200;
      2: return 15'o77777;
      3: return 15'o00300;
      default: begin
        t = $urandom();
        return t[14:0];
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock; the memory side answers mem_req after lat_cnt wait cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          snap = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
        end
        if (lat_cnt == 0) begin
          chk("mem_hold", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata} != {snap.we, snap.addr, snap.wdata}), 64'(0));
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            bus.mem_rdata = rnd48();
            tb_mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = rd_world(bus.mem_addr);
          end
          acc_q.push_back(snap);
          req_seen = 1'b0;
          lat_cnt  = int'($urandom_range(lat_max, 0));
        end else begin
          lat_cnt--;
        end
      end
    end
  endtask

  // Core-side transaction: hold requests with the ALU busy, then retire.
  task automatic run_txn(input string tag, input logic f, input logic r, input logic w,
                         input logic [14:0] ia, input logic [14:0] da,
                         input logic [47:0] dout, input int busy);
    int t;
    bit d_seen, d_drop, hold_bad;
    t = 0; d_seen = 1'b0; d_drop = 1'b0; hold_bad = 1'b0;
    acc_q.delete();
    bus.alu_busy = 1'b1;
    bus.ibus_fetch = f; bus.dbus_read = r; bus.dbus_write = w;
    bus.ibus_addr = ia; bus.dbus_addr = da; bus.dbus_output = dout;
    while (((f && !bus.ibus_done) || ((r || w) && !bus.dbus_done)) && t < 60) begin
      tick();
      t++;
      if (bus.dbus_done) d_seen = 1'b1;
      else if (d_seen) d_drop = 1'b1;
    end
    chk({tag, "_timeout"}, 64'(t >= 60), 64'(0));
    chk({tag, "_dbus_done_sticky"}, 64'(d_drop), 64'(0));
    chk({tag, "_ibus_done_req"}, 64'(bus.ibus_done), 64'(f));
    for (int k = 0; k < busy; k++) begin
      tick();
      if (bus.ibus_done !== f || bus.dbus_done !== (r | w)) hold_bad = 1'b1;
    end
    chk({tag, "_done_hold"}, 64'(hold_bad), 64'(0));
    bus.alu_busy = 1'b0;
    tick();
    chk({tag, "_retire_clear"}, 64'({bus.ibus_done, bus.dbus_done, bus.mem_req}), 64'(0));
    bus.ibus_fetch = 1'b0; bus.dbus_read = 1'b0; bus.dbus_write = 1'b0;
    tick();
    chk({tag, "_no_reissue"}, 64'(bus.mem_req), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        f, r, w, hit, mvalid;
    logic [14:0] ia, da, mlast;
    logic [47:0] dout, mi, md;
    bit          seq_bad;

    checks = 0; errors = 0;
    auto_mem = 1'b1; req_seen = 1'b0; lat_cnt = 0; lat_max = 0;
    reset = 1'b1;
    bus.ibus_fetch = 1'b0; bus.ibus_addr = 15'd0; bus.dbus_read = 1'b0; bus.dbus_write = 1'b0;
    bus.dbus_addr = 15'd0; bus.dbus_output = 48'd0; bus.alu_busy = 1'b0;
    bus.mem_rdata = 48'd0; bus.mem_ack = 1'b0;
    tb_mem[15'o00100] = 48'h123456789ABC;
    tb_mem[15'o00200] = 48'hA5A500001234;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 15'o00100, 15'o00000, 48'h0, 0, 1, 15'o00100, 15'o00000, 1'b0, 48'h123456789ABC, 48'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 15'o00100, 15'o00200, 48'h0, 0, HIT_EN ? 1 : 2, 15'o00200, 15'o00100, 1'b0, 48'h123456789ABC, 48'hA5A500001234};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 15'o00000, 15'o77777, 48'hFFFF00000001, 1, 1, 15'o77777, 15'o00000, 1'b1, 48'h123456789ABC, 48'hA5A500001234};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 15'o00000, 15'o77777, 48'h0, 5, 1, 15'o77777, 15'o00000, 1'b0, 48'h123456789ABC, 48'hFFFF00000001};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 15'o00000, 15'o00100, 48'h0000DEADBEEF, 0, 1, 15'o00100, 15'o00000, 1'b1, 48'h123456789ABC, 48'hFFFF00000001};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 15'o00100, 15'o00000, 48'h0, 0, 1, 15'o00100, 15'o00000, 1'b0, 48'h0000DEADBEEF, 48'hFFFF00000001};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 15'o00100, 15'o00000, 48'h0, 2, HIT_EN ? 0 : 1, 15'o00100, 15'o00000, 1'b0, 48'h0000DEADBEEF, 48'hFFFF00000001};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 15'o00000, 15'o00300, 48'h000000000111, 0, 1, 15'o00300, 15'o00000, 1'b1, 48'h0000DEADBEEF, 48'hFFFF00000001};

    #23 reset = 1'b0;
    chk("reset_state", 64'({bus.mem_req, bus.mem_we, bus.ibus_done, bus.dbus_done, bus.mem_addr}), 64'(0));
    chk("reset_data", 64'(bus.ibus_input | bus.dbus_input | bus.mem_wdata), 64'(0));
    tick();

    // Zero-wait fetch latency: mem_req one cycle after the request, done one after that.
    bus.ibus_fetch = 1'b1; bus.ibus_addr = 15'o00100; bus.alu_busy = 1'b0;
    tick();
    chk("lat_mem_req", 64'({bus.mem_req, bus.ibus_done}), 64'(2'b10));
    chk("lat_mem_addr", 64'(bus.mem_addr), 64'(15'o00100));
    tick();
    chk("lat_ibus_done", 64'({bus.ibus_done, bus.mem_req}), 64'(2'b10));
    chk("lat_ibus_input", 64'(bus.ibus_input), 64'(48'h123456789ABC));
    tick();
    chk("lat_retire", 64'({bus.ibus_done, bus.mem_req}), 64'(0));
    chk("lat_input_held", 64'(bus.ibus_input), 64'(48'h123456789ABC));
    bus.ibus_fetch = 1'b0;
    tick();

    // Reset during DBUS_WAIT, then a late ack that must be ignored.
    auto_mem = 1'b0;
    bus.dbus_read = 1'b1; bus.dbus_addr = 15'o00200;
    tick();
    tick();
    chk("rst_pre_req", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, 15'o00200}));
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", 64'({bus.mem_req, bus.mem_we, bus.ibus_done, bus.dbus_done, bus.mem_addr}), 64'(0));
    chk("rst_mid_data", 64'(bus.ibus_input | bus.dbus_input | bus.mem_wdata), 64'(0));
    bus.dbus_read = 1'b0;
    #2 reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 48'h5A5A5A5A5A5A;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("late_ack_ignored", 64'({bus.dbus_done, bus.ibus_done, bus.mem_req}), 64'(0));
    chk("late_ack_data", 64'(bus.dbus_input | bus.ibus_input), 64'(0));
    auto_mem = 1'b1; req_seen = 1'b0; lat_cnt = 0;

    // Vector table.
    lat_max = 2;
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("row%0d", i), vecs[i].f, vecs[i].r, vecs[i].w, vecs[i].ia,
              vecs[i].da, vecs[i].dout, vecs[i].busy);
      chk($sformatf("row%0d_nacc", i), 64'(acc_q.size()), 64'(vecs[i].n));
      if (vecs[i].n > 0 && acc_q.size() > 0) begin
        chk($sformatf("row%0d_addr0", i), 64'({acc_q[0].we, acc_q[0].addr}), 64'({vecs[i].we0, vecs[i].a0}));
        if (vecs[i].we0) chk($sformatf("row%0d_wdata", i), 64'(acc_q[0].wdata), 64'(vecs[i].dout));
      end
      if (vecs[i].n > 1 && acc_q.size() > 1)
        chk($sformatf("row%0d_addr1", i), 64'({acc_q[1].we, acc_q[1].addr}), 64'({1'b0, vecs[i].a1}));
      chk($sformatf("row%0d_ibus_input", i), 64'(bus.ibus_input), 64'(vecs[i].ei));
      chk($sformatf("row%0d_dbus_input", i), 64'(bus.dbus_input), 64'(vecs[i].ed));
    end

    // Random transactions against a transaction-level model.
    mmem = tb_mem;
    mi = 48'h0000DEADBEEF; md = 48'hFFFF00000001; mvalid = 1'b1; mlast = 15'o00100;
    for (int n = 0; n < 150; n++) begin
      do begin
        f = 1'($urandom_range(1, 0)); r = 1'($urandom_range(1, 0)); w = 1'($urandom_range(1, 0));
      end while (!(f | r | w));
      ia = pick_addr(); da = pick_addr(); dout = rnd48();
      exp_q.delete();
      if (r | w) begin
        exp_q.push_back('{w, da, dout});
        if (w) begin
          mmem[da] = dout;
          if (da == mlast) mvalid = 1'b0;
        end else begin
          md = rd_model(da);
        end
      end
      if (f) begin
        hit = HIT_EN && mvalid && (mlast == ia);
        if (!hit) begin
          exp_q.push_back('{1'b0, ia, 48'h0});
          mi = rd_model(ia); mlast = ia; mvalid = 1'b1;
        end
      end
      run_txn($sformatf("rnd%0d", n), f, r, w, ia, da, dout, int'($urandom_range(2, 0)));
      chk($sformatf("rnd%0d_nacc", n), 64'(acc_q.size()), 64'(exp_q.size()));
      seq_bad = 1'b0;
      for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
        if (acc_q[k].we !== exp_q[k].we || acc_q[k].addr !== exp_q[k].addr) seq_bad = 1'b1;
        if (exp_q[k].we && acc_q[k].wdata !== exp_q[k].wdata) seq_bad = 1'b1;
      end
      chk($sformatf("rnd%0d_access_seq", n), 64'(seq_bad), 64'(0));
      chk($sformatf("rnd%0d_ibus_input", n), 64'(bus.ibus_input), 64'(mi));
      chk($sformatf("rnd%0d_dbus_input", n), 64'(bus.dbus_input), 64'(md));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesm6_mem_arbiter.md
Name: mesm6_mem_arbiter

Overview:
- Sits directly downstream of mesm6_core. Merges the core's instruction bus (ibus_*) and data bus (dbus_*) onto one single-ported 48-bit external memory port (mem_*).
- Serialises concurrent requests with fixed priority and holds each channel's done and read data stable while the core stalls.
- Read-data registers feed ibus_input and dbus_input.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 48, data word width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ibus_fetch  in  1  instruction read request, level, held while the core stalls.
- ibus_addr  in  ADDR_W  instruction word address.
- ibus_input  out  DATA_W  instruction word read, held.
- ibus_done  out  1  instruction request served, sticky until retire.
- dbus_read  in  1  data read request, level.
- dbus_write  in  1  data write request, level.
- dbus_addr  in  ADDR_W  data address.
- dbus_output  in  DATA_W  write data from the core accumulator.
- dbus_input  out  DATA_W  data word read, held.
- dbus_done  out  1  data request served, sticky until retire.
- alu_busy  in  1  core stalled by the ALU; blocks retire.
- mem_req  out  1  external request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  external address.
- mem_wdata  out  DATA_W  external write data.
- mem_rdata  in  DATA_W  external read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): state=IDLE. mem_req, mem_we, ibus_done, dbus_done = 0. mem_addr, mem_wdata, ibus_input, dbus_input = 0. Any in-flight memory transaction is abandoned; an ack arriving after reset in IDLE is ignored.
- Pending conditions:
  - ipend = ibus_fetch & ~ibus_done.
  - dpend = (dbus_read | dbus_write) & ~dbus_done.
- dbus_read & dbus_write together is treated as a write.
- FSM states: IDLE, DBUS_WAIT, IBUS_WAIT. All outputs are registered.
- IDLE:
  - If dpend: register mem_addr=dbus_addr, mem_we=dbus_write, mem_wdata=dbus_output, mem_req=1; go DBUS_WAIT.
  - Else if ipend: mem_addr=ibus_addr, mem_we=0, mem_req=1; go IBUS_WAIT.
  - dbus has fixed priority over ibus.
- DBUS_WAIT:
  - mem_req, mem_addr, mem_we, mem_wdata stay stable until mem_ack.
  - On mem_ack: mem_req=0, dbus_done=1; on a read, dbus_input<=mem_rdata; on a write, dbus_input is unchanged. Go IDLE.
- IBUS_WAIT: same as DBUS_WAIT; on mem_ack, ibus_input<=mem_rdata and ibus_done=1.
- mem_ack outside a WAIT state is ignored.
- Latency: request first seen in cycle N → mem_req=1 in N+1; mem_ack in cycle M → done=1 in M+1. With a zero-wait memory (ack in N+1), done is visible in N+2.
- Retire condition: (~ibus_fetch | ibus_done) & (~(dbus_read|dbus_write) | dbus_done) & (ibus_fetch | dbus_read | dbus_write) & ~alu_busy.
- At the retire edge, both done flags clear. A request still asserted on the following cycle is a new transaction.
- A done flag never clears before retire. This prevents losing an early ibus_done while dbus is still pending.
- Simultaneous fetch+read: dbus is served, then ibus; both dones are high together at the end.
- Read-data registers change only on an ack for their own channel.
- Back-to-back requests cost one IDLE cycle; no pipelining.

Optional Feature:
- Macro MESM6_MEM_IBUS_HIT_EN.
- Defined:
  - Keep last_iaddr plus a valid bit, set on every ibus ack.
  - In IDLE, with no dpend and ipend with ibus_addr==last_iaddr & valid: set ibus_done=1 the next cycle with no mem_req. ibus_input is unchanged.
  - Any dbus write ack whose address equals last_iaddr clears valid. Reset clears valid.
- Undefined: every fetch goes to memory.

Decomposition:
- Package mesm6_mem_pkg holds the state enum (IDLE, DBUS_WAIT, IBUS_WAIT) and localparams ADDR_W=15, DATA_W=48.
- One sub-module, mesm6_mem_chan, instantiated twice: sticky done flag, held read-data register, pend output, clear-on-retire input.

Test Plan:
- Fetch only:
  - Stimulus: ibus_fetch=1, ibus_addr='o00100, memory acks one cycle after mem_req with 'h123456789ABC.
  - Required: mem_req in N+1, ibus_done in N+2, ibus_input='h123456789ABC held until retire.
- Concurrent fetch and read:
  - Stimulus: dbus_read @ 'o00200 and ibus_fetch @ 'o00100 in the same cycle.
  - Required: first mem_addr='o00200, second 'o00100; dbus_done stays high across the ibus access; both dones clear at retire.
- Write:
  - Stimulus: dbus_write, dbus_addr='o77777, dbus_output='hFFFF00000001.
  - Required: mem_we=1, mem_wdata held until ack; dbus_input unchanged.
- ALU stall:
  - Stimulus: read completes while alu_busy=1 for 5 cycles.
  - Required: dbus_done stays 1 for those 5 cycles, clears the edge after alu_busy falls, and no second memory access occurs.
- Reset mid-transaction:
  - Stimulus: assert reset during DBUS_WAIT, then deliver a late mem_ack.
  - Required: all outputs 0 immediately; the ack causes no done and no data change.
- MESM6_MEM_IBUS_HIT_EN:
  - Stimulus: repeat a fetch to 'o00100 → done with no mem_req; then write 'o00100 and fetch again.
  - Required: the fetch after the write goes to memory.
